// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Arbiter FSM: either searching for a requester or locked onto one.
  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_t;

  // Bits needed to index/count values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Increment modulo n; used to move the round-robin pointer past the last owner.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between requesters, the arbiter and the serializer.
// The arbiter takes the slave view; the client/serializer side takes the master view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;

  logic                               tx_valid;
  logic [DATA_WIDTH-1:0]              tx_data;
  logic                               tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic            found,
  output logic [PtrW-1:0] idx
);

  logic [PtrW-1:0] cand;

  // Walk ptr, ptr+1, ... and latch the first requester seen.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = PtrW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between NUM_REQ byte-stream requesters.
// Round-robin grant held for a whole message, capped by MAX_BURST bytes and
// an idle timeout. The outgoing byte sits in a single register stage.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rstn,
  uart_tx_arbiter_if.slave                    bus,
  output logic [clog2_min1(NUM_REQ)-1:0]      grant_id,
  output logic                                busy
);

  localparam int unsigned PtrW   = clog2_min1(NUM_REQ);
  localparam int unsigned BurstW = clog2_min1(MAX_BURST + 1);
  localparam int unsigned IdleW  = clog2_min1(IDLE_TIMEOUT + 1);

  // Counter values on which the current accept / idle cycle ends the grant.
  localparam logic [BurstW-1:0] BurstLast = BurstW'((MAX_BURST != 0) ? MAX_BURST - 1 : 0);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'((IDLE_TIMEOUT != 0) ? IDLE_TIMEOUT - 1 : 0);

  arb_state_t            state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       grant_q, grant_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0]    req_ready;
  logic                  pick_found;
  logic [PtrW-1:0]       pick_idx;
  logic                  slot_free;
  logic                  accept;
  logic                  drop;

  uart_tx_arbiter_rr_pick #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitration, grant release, counters and the output byte register.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    burst_d    = burst_q;
    idle_d     = idle_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    req_ready  = '0;
    accept     = 1'b0;
    drop       = 1'b0;
    // The output register can take a byte if empty or being drained this cycle.
    slot_free  = !tx_valid_q || bus.tx_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[grant_q] = slot_free;
        accept             = bus.req_valid[grant_q] && slot_free;
        if (accept) begin
          burst_d = burst_q + BurstW'(1);
          idle_d  = '0;
          drop    = bus.req_last[grant_q] || ((MAX_BURST != 0) && (burst_q == BurstLast));
        end else if (!bus.req_valid[grant_q]) begin
          // Stalled only counts when the owner has nothing; backpressure is not idle.
          idle_d = idle_q + IdleW'(1);
          drop   = (IDLE_TIMEOUT != 0) && (idle_q == IdleLast);
        end
        if (drop) begin
          state_d = ST_IDLE;
          ptr_d   = PtrW'(wrap_inc(32'(grant_q), NUM_REQ));
          burst_d = '0;
          idle_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new byte overwrites a draining one in the same cycle, so no bubble.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.req_data[grant_q];
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset; reset drops any buffered byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      burst_q    <= '0;
      idle_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      burst_q    <= burst_d;
      idle_q     <= idle_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == ST_GRANT);

endmodule
